// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and constants for the clock-divider sequencer (clk_div_ctrl).
// Optional macro CLK_DIV_CTRL_ROUND_ROBIN_EN selects round-robin arbitration.
package clk_div_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GATE   = 3'd1,
        LOAD   = 3'd2,
        UNGATE = 3'd3,
        ACK    = 3'd4
    } state_e;

    // Ratios below this cannot be programmed into the divider.
    localparam int MIN_RATIO = 2;

endpackage

// File: rtl/clk_div_ctrl_arb.sv
// Requester arbiter for clk_div_ctrl: one-hot grant plus encoded index, only while enable is high.
// CLK_DIV_CTRL_ROUND_ROBIN_EN defined: round-robin; otherwise fixed priority (lowest index wins).
module clk_div_ctrl_arb #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
`ifdef CLK_DIV_CTRL_ROUND_ROBIN_EN
    input  logic               ref_clk,
    input  logic               reset,
`endif
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic found;

`ifdef CLK_DIV_CTRL_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idx;

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (enable && req[idx] && !found) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    // Every grant ends in exactly one ack or nack, so advancing at grant time tracks the last winner.
    // NOTE: sequential state uses non-blocking assignments and an asynchronous active-low reset.
    always_ff @(posedge ref_clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`else
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (enable && req[i] && !found) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/clk_div_ctrl.sv
// Glitch-safe sequencer for the programmable clock divider: gate, settle, load, ungate, settle, ack.
// CLK_DIV_CTRL_ROUND_ROBIN_EN selects round-robin arbitration in clk_div_ctrl_arb.
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int DIV_RATIO_WIDTH = 4,
    parameter int NUM_REQ         = 2,
    parameter int SETTLE_CYCLES   = 4,
    parameter int RESET_RATIO     = 2
) (
    input  logic                               ref_clk,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ*DIV_RATIO_WIDTH-1:0] req_ratio,
    output logic [NUM_REQ-1:0]                 ack,
    output logic [NUM_REQ-1:0]                 nack,
    output logic                               busy,
    output logic                               div_enable,
    output logic [DIV_RATIO_WIDTH-1:0]         div_ratio
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]           CNT_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [DIV_RATIO_WIDTH-1:0] MIN_R     = DIV_RATIO_WIDTH'(MIN_RATIO);
    localparam logic [DIV_RATIO_WIDTH-1:0] RST_RATIO = DIV_RATIO_WIDTH'(RESET_RATIO);

    state_e                     state, state_nxt;
    logic [CNT_W-1:0]           cnt, cnt_nxt;
    logic [DIV_RATIO_WIDTH-1:0] ratio_q, ratio_nxt, div_ratio_nxt, sel_ratio;
    logic [IDX_W-1:0]           owner_q, owner_nxt, grant_idx;
    logic [NUM_REQ-1:0]         grant, ack_nxt, nack_nxt;
    logic                       div_enable_nxt, arb_en;

    // A response cycle is never an arbitration cycle, so a requester always gets one cycle to drop req.
    assign arb_en = (state == IDLE) && !(|ack) && !(|nack);
    assign busy   = (state != IDLE);

    clk_div_ctrl_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
`ifdef CLK_DIV_CTRL_ROUND_ROBIN_EN
        .ref_clk   (ref_clk),
        .reset     (reset),
`endif
        .req       (req),
        .enable    (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_ratio = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) sel_ratio = req_ratio[i*DIV_RATIO_WIDTH +: DIV_RATIO_WIDTH];
        end
    end

    // Outputs are computed for the next state and registered, so each lands in the cycle its state starts.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        ratio_nxt      = ratio_q;
        owner_nxt      = owner_q;
        div_enable_nxt = div_enable;
        div_ratio_nxt  = div_ratio;
        ack_nxt        = '0;
        nack_nxt       = '0;
        case (state)
            IDLE: begin
                if (|grant) begin
                    ratio_nxt = sel_ratio;
                    owner_nxt = grant_idx;
                    if (sel_ratio < MIN_R) begin
                        nack_nxt = grant;
                    end else if (sel_ratio == div_ratio && div_enable) begin
                        ack_nxt = grant;
                    end else begin
                        state_nxt      = GATE;
                        cnt_nxt        = CNT_LOAD;
                        div_enable_nxt = 1'b0;
                    end
                end
            end
            GATE: begin
                if (cnt == '0) begin
                    state_nxt     = LOAD;
                    div_ratio_nxt = ratio_q;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            LOAD: begin
                state_nxt      = UNGATE;
                cnt_nxt        = CNT_LOAD;
                div_enable_nxt = 1'b1;
            end
            UNGATE: begin
                if (cnt == '0) begin
                    state_nxt        = ACK;
                    ack_nxt[owner_q] = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ref_clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            ratio_q    <= '0;
            owner_q    <= '0;
            div_enable <= 1'b0;
            div_ratio  <= RST_RATIO;
            ack        <= '0;
            nack       <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            ratio_q    <= ratio_nxt;
            owner_q    <= owner_nxt;
            div_enable <= div_enable_nxt;
            div_ratio  <= div_ratio_nxt;
            ack        <= ack_nxt;
            nack       <= nack_nxt;
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios plus random requests against a transaction model.
// Honours CLK_DIV_CTRL_ROUND_ROBIN_EN for the expected arbitration order.
module tb_clk_div_ctrl;

    localparam int W = 4;
    localparam int N = 2;
    localparam int S = 4;
    localparam int RST_R = 2;

    logic           ref_clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_ratio;
    logic [N-1:0]   ack, nack;
    logic           busy, div_enable;
    logic [W-1:0]   div_ratio;

    int vectors;
    int miscompares;

    // Transaction-level model of the divider programming state.
    int m_ratio;
    bit m_en;
    int m_ptr;

    clk_div_ctrl #(
        .DIV_RATIO_WIDTH (W),
        .NUM_REQ         (N),
        .SETTLE_CYCLES   (S),
        .RESET_RATIO     (RST_R)
    ) dut (
        .ref_clk    (ref_clk),
        .reset      (reset),
        .req        (req),
        .req_ratio  (req_ratio),
        .ack        (ack),
        .nack       (nack),
        .busy       (busy),
        .div_enable (div_enable),
        .div_ratio  (div_ratio)
    );

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " ack"}, 32'(ack), 32'd0);
        check({tag, " nack"}, 32'(nack), 32'd0);
        check({tag, " en"}, 32'(div_enable), 32'(m_en));
        check({tag, " ratio"}, 32'(div_ratio), 32'(m_ratio));
    endtask

    function automatic int model_winner(input logic [N-1:0] r);
`ifdef CLK_DIV_CTRL_ROUND_ROBIN_EN
        for (int k = 0; k < N; k++) begin
            if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (r[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic set_req(input int i, input int ratio);
        req_ratio[i*W +: W] = W'(ratio);
        req[i] = 1'b1;
    endtask

    // Entered at a negedge whose following posedge is an arbitration edge; leaves in the same condition.
    task automatic run_txn(input string tag, input bit drop_at_resp, input int drop_cycle);
        int w, r, kind, len, old_ratio;
        logic [N-1:0] exp_ack, exp_nack;
        w = model_winner(req);
        if (w < 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: no request pending, observed req %0h expected nonzero", tag, req);
            return;
        end
        r = int'(req_ratio[w*W +: W]);
        kind = (r < 2) ? 0 : ((r == m_ratio && m_en) ? 1 : 2);
        len = (kind == 2) ? 2*S + 2 : 1;
        old_ratio = m_ratio;
        @(posedge ref_clk);
        for (int k = 1; k <= len; k++) begin
            @(negedge ref_clk);
            exp_ack  = ((kind == 1) || (kind == 2 && k == len)) ? N'(1 << w) : '0;
            exp_nack = (kind == 0) ? N'(1 << w) : '0;
            check($sformatf("%s c%0d ack", tag, k), 32'(ack), 32'(exp_ack));
            check($sformatf("%s c%0d nack", tag, k), 32'(nack), 32'(exp_nack));
            check($sformatf("%s c%0d busy", tag, k), 32'(busy), 32'(kind == 2));
            check($sformatf("%s c%0d en", tag, k), 32'(div_enable),
                  (kind == 2) ? 32'(k >= S + 2) : 32'(m_en));
            check($sformatf("%s c%0d ratio", tag, k), 32'(div_ratio),
                  (kind == 2 && k >= S + 1) ? 32'(r) : 32'(old_ratio));
            if (k == drop_cycle || (k == len && drop_at_resp)) req[w] = 1'b0;
        end
        if (kind == 2) begin
            m_ratio = r;
            m_en    = 1'b1;
        end
        m_ptr = (w + 1) % N;
        @(negedge ref_clk);
        check_idle({tag, " after"});
    endtask

    initial begin
        int pick;
        vectors     = 0;
        miscompares = 0;
        m_ratio     = RST_R;
        m_en        = 1'b0;
        m_ptr       = 0;
        reset       = 1'b0;
        req         = '0;
        req_ratio   = '0;

        repeat (3) @(negedge ref_clk);
        check_idle("reset");
        reset = 1'b1;
        @(negedge ref_clk);
        check_idle("post-reset");

        // First program, then same ratio while enabled.
        set_req(0, 4);
        run_txn("prog4", 1'b1, 0);
        set_req(0, 4);
        run_txn("same4", 1'b1, 0);

        // Rejected ratios leave the divider untouched.
        set_req(1, 1);
        run_txn("rej1", 1'b1, 0);
        set_req(1, 0);
        run_txn("rej0", 1'b1, 0);

        // Two requesters held together.
        set_req(0, 3);
        set_req(1, 6);
`ifdef CLK_DIV_CTRL_ROUND_ROBIN_EN
        run_txn("both a", 1'b0, 0);
        run_txn("both b", 1'b0, 0);
        run_txn("both c", 1'b0, 0);
        run_txn("both d", 1'b0, 0);
        req = '0;
`else
        run_txn("both a", 1'b0, 0);
        run_txn("both b", 1'b0, 0);
        req[0] = 1'b0;
        run_txn("both c", 1'b1, 0);
`endif
        @(negedge ref_clk);

        // Reset in cycle 7 of a sequence.
        set_req(0, (m_ratio == 7) ? 9 : 7);
        @(posedge ref_clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge ref_clk);
            check($sformatf("rst-mid c%0d busy", k), 32'(busy), 32'd1);
        end
        reset = 1'b0;
        #1;
        m_ratio = RST_R;
        m_en    = 1'b0;
        m_ptr   = 0;
        check_idle("rst-mid now");
        req = '0;
        repeat (2) @(negedge ref_clk);
        check_idle("rst-mid held");
        reset = 1'b1;
        repeat (3) begin
            @(negedge ref_clk);
            check_idle("rst-mid release");
        end
        set_req(0, 5);
        run_txn("after-rst", 1'b1, 0);

        // Requester 1 drops req during GATE; the sequence still completes.
        set_req(1, (m_ratio == 9) ? 11 : 9);
        run_txn("drop-gate", 1'b0, 2);

        // Random requests against the model.
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && ($urandom_range(0, 1) == 1)) begin
                    pick = int'($urandom_range(0, 3));
                    if (pick == 0)      set_req(i, int'($urandom_range(0, 1)));
                    else if (pick == 1) set_req(i, m_ratio);
                    else                set_req(i, int'($urandom_range(2, 15)));
                end
            end
            if (req == '0) set_req(int'($urandom_range(0, N - 1)), int'($urandom_range(2, 15)));
            run_txn($sformatf("rand%0d", it), 1'b1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
